// File: rtl/fifo_sched_pkg.sv
// Shared types for the flux scheduler: FSM state encoding and one-hot to index helper.
// Purely declarative, no latency or backpressure of its own.
package fifo_sched_pkg;

    localparam int MAX_FLUX = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Callers zero-extend their one-hot vector to MAX_FLUX bits; a zero vector maps to 0.
    function automatic int onehot_idx(input logic [MAX_FLUX-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_FLUX; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit scanning upward from ptr with wrap; one-hot or zero gnt.
// Purely combinational, zero latency; a flux that is not requesting is simply skipped.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + i) % N)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin reader of a shared tagged FIFO into per-flux output registers; read is combinational,
// words visible one cycle after the read; a flux is only read when its register is empty or draining.
module fifo_rr_sched
    import fifo_sched_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FLUX       = 2,
    localparam int TAG_WIDTH  = $clog2(FLUX),
    localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [FLUX-1:0]                     mask,
    input  logic [FLUX-1:0]                     empty,
    input  logic [WIDTH-1:0]                    fifo_dout,
    output logic [FLUX-1:0]                     read,
    output logic [FLUX-1:0]                     out_valid,
    output logic [FLUX-1:0][DATA_WIDTH-1:0]     out_data,
    input  logic [FLUX-1:0]                     out_ready,
    output logic                                busy,
    output logic                                tag_err
);

    state_t                 state;
    logic [TAG_WIDTH-1:0]   rr_ptr;
    logic [FLUX-1:0]        elig;
    int                     gnt_idx;
    logic [TAG_WIDTH-1:0]   gnt_tag;
    logic [TAG_WIDTH-1:0]   next_ptr;
    logic [TAG_WIDTH-1:0]   word_tag;

    // A full register may be refilled on the same edge it is drained.
    always_comb begin
        elig = '0;
        if (state == RUN) elig = mask & ~empty & (~out_valid | out_ready);
    end

    rr_arbiter #(.N(FLUX)) u_arb (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (read)
    );

    always_comb begin
        gnt_idx = onehot_idx(MAX_FLUX'(read));
    end

    assign gnt_tag  = TAG_WIDTH'(gnt_idx);
    assign next_ptr = (gnt_idx == FLUX - 1) ? '0 : TAG_WIDTH'(gnt_idx + 1);
    assign word_tag = fifo_dout[WIDTH-1 -: TAG_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            out_valid <= '0;
            out_data  <= '0;
            tag_err   <= 1'b0;
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (read[f]) begin
                    out_data[f]  <= fifo_dout[DATA_WIDTH-1:0];
                    out_valid[f] <= 1'b1;
                end else if (out_ready[f]) begin
                    out_valid[f] <= 1'b0;
                end
            end
            if (|read) begin
                rr_ptr <= next_ptr;
                if (word_tag != gnt_tag) tag_err <= 1'b1;
            end
        end
    end

    // busy is registered alongside the state so it never glitches with the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) state <= DRAIN;
                end
                DRAIN: begin
                    if (en) begin
                        state <= RUN;
                    end else if (out_valid == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched (FLUX=2, DATA_WIDTH=8): directed vector table, corner sequences, random run
// against a cycle-level reference model of the scheduler's rules.
module tb_fifo_rr_sched;

    localparam int DW = 8;
    localparam int FL = 2;
    localparam int W  = DW + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [FL-1:0]      mask;
    logic [FL-1:0]      empty;
    logic [W-1:0]       fifo_dout;
    logic [FL-1:0]      read;
    logic [FL-1:0]      out_valid;
    logic [FL-1:0][DW-1:0] out_data;
    logic [FL-1:0]      out_ready;
    logic               busy;
    logic               tag_err;

    always #5 clk = ~clk;

    fifo_rr_sched #(.DATA_WIDTH(DW), .FLUX(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mask      (mask),
        .empty     (empty),
        .fifo_dout (fifo_dout),
        .read      (read),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .tag_err   (tag_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: 0 = idle, 1 = running, 2 = draining.
    int         m_state;
    int         m_ptr;
    bit         m_valid [FL];
    logic [7:0] m_data  [FL];
    bit         m_terr;

    logic [1:0] last_read;
    logic [1:0] last_valid;
    logic       last_busy;

    typedef struct {
        logic        en;
        logic [1:0]  mask;
        logic [1:0]  empty;
        logic [1:0]  ready;
        logic [8:0]  dout;
        logic [1:0]  x_read;
        logic [1:0]  x_valid;
        logic [15:0] x_data;
        logic        x_busy;
        logic        x_terr;
    } vec_t;

    vec_t tbl [18];
    vec_t none_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_read();
        logic [1:0] r;
        bit found;
        r = 2'b00;
        found = 1'b0;
        if (m_state == 1) begin
            for (int k = 0; k < FL; k++) begin
                int f;
                f = (m_ptr + k) % FL;
                if (!found && mask[f] && !empty[f] && (!m_valid[f] || out_ready[f])) begin
                    r[f] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_terr  = 1'b0;
        for (int f = 0; f < FL; f++) begin
            m_valid[f] = 1'b0;
            m_data[f]  = 8'h00;
        end
    endtask

    task automatic model_update(input logic [1:0] er);
        bit none_held;
        int g;
        none_held = !m_valid[0] && !m_valid[1];
        for (int f = 0; f < FL; f++) begin
            if (er[f]) begin
                m_data[f]  = fifo_dout[7:0];
                m_valid[f] = 1'b1;
            end else if (m_valid[f] && out_ready[f]) begin
                m_valid[f] = 1'b0;
            end
        end
        if (er != 2'b00) begin
            g = er[1] ? 1 : 0;
            m_ptr = (g + 1) % FL;
            if (int'(fifo_dout[8]) != g) m_terr = 1'b1;
        end
        case (m_state)
            0: if (en) m_state = 1;
            1: if (!en) m_state = 2;
            default: begin
                if (en) m_state = 1;
                else if (none_held) m_state = 0;
            end
        endcase
    endtask

    // Entered just after a rising edge with inputs already applied; leaves just after the next one.
    task automatic step(input bit use_tbl, input vec_t v, input int idx);
        logic [1:0] er;
        @(negedge clk);
        er = model_read();
        last_read  = read;
        last_valid = out_valid;
        last_busy  = busy;
        chk("read", 32'(read), 32'(er));
        chk("out_valid", 32'(out_valid), 32'({m_valid[1], m_valid[0]}));
        chk("out_data", 32'(out_data), 32'({m_data[1], m_data[0]}));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("tag_err", 32'(tag_err), 32'(m_terr));
        if (use_tbl) begin
            chk($sformatf("tbl%0d_read", idx), 32'(read), 32'(v.x_read));
            chk($sformatf("tbl%0d_valid", idx), 32'(out_valid), 32'(v.x_valid));
            chk($sformatf("tbl%0d_data", idx), 32'(out_data), 32'(v.x_data));
            chk($sformatf("tbl%0d_busy", idx), 32'(busy), 32'(v.x_busy));
            chk($sformatf("tbl%0d_tag_err", idx), 32'(tag_err), 32'(v.x_terr));
        end
        @(posedge clk);
        model_update(er);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic [1:0] em,
                         input logic [1:0] rd, input logic [8:0] d);
        en = e; mask = m; empty = em; out_ready = rd; fifo_dout = d;
    endtask

    // Asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_read", 32'(read), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tag_err", 32'(tag_err), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'b11, 2'b00, 2'b11, 9'h011, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b11, 2'b00, 2'b11, 9'h022, 2'b01, 2'b00, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 2'b11, 2'b00, 2'b11, 9'h133, 2'b10, 2'b01, 16'h0022, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 2'b11, 2'b00, 2'b11, 9'h044, 2'b01, 2'b10, 16'h3322, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 2'b11, 2'b00, 2'b11, 9'h155, 2'b10, 2'b01, 16'h3344, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 2'b11, 2'b00, 2'b10, 9'h066, 2'b01, 2'b10, 16'h5544, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 2'b11, 2'b00, 2'b10, 9'h177, 2'b10, 2'b01, 16'h5566, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 2'b11, 2'b00, 2'b10, 9'h188, 2'b10, 2'b11, 16'h7766, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 2'b11, 2'b00, 2'b10, 9'h199, 2'b10, 2'b11, 16'h8866, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 2'b10, 2'b00, 2'b11, 9'h1A0, 2'b10, 2'b11, 16'h9966, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 2'b10, 2'b00, 2'b11, 9'h1A1, 2'b10, 2'b10, 16'hA066, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 2'b11, 2'b00, 2'b11, 9'h0B0, 2'b01, 2'b10, 16'hA166, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 2'b11, 2'b00, 2'b11, 9'h0B1, 2'b10, 2'b01, 16'hA1B0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 2'b11, 2'b11, 2'b00, 9'h000, 2'b00, 2'b10, 16'hB1B0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 2'b11, 2'b11, 2'b00, 9'h000, 2'b00, 2'b10, 16'hB1B0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 2'b11, 2'b11, 2'b10, 9'h000, 2'b00, 2'b10, 16'hB1B0, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 2'b11, 2'b11, 2'b00, 9'h000, 2'b00, 2'b00, 16'hB1B0, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 2'b11, 2'b11, 2'b00, 9'h000, 2'b00, 2'b00, 16'hB1B0, 1'b0, 1'b1};
        none_v  = tbl[0];

        drive(1'b0, 2'b00, 2'b11, 2'b00, 9'h000);
        do_reset();

        // Alternation, stalled flux, mask, tag error, drain to idle.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].en, tbl[i].mask, tbl[i].empty, tbl[i].ready, tbl[i].dout);
            step(1'b1, tbl[i], i);
        end

        // Both registers full when en falls; downstream wakes two cycles later.
        do_reset();
        drive(1'b1, 2'b11, 2'b00, 2'b00, 9'h0C0);
        step(1'b0, none_v, 0);
        step(1'b0, none_v, 0);
        fifo_dout = 9'h1C1;
        step(1'b0, none_v, 0);
        chk("fill_valid", 32'(out_valid), 32'h3);
        drive(1'b0, 2'b11, 2'b00, 2'b00, 9'h0C2);
        step(1'b0, none_v, 0);
        chk("drain_read_a", 32'(last_read), 32'h0);
        step(1'b0, none_v, 0);
        chk("drain_read_b", 32'(last_read), 32'h0);
        out_ready = 2'b11;
        step(1'b0, none_v, 0);
        chk("drain_read_c", 32'(last_read), 32'h0);
        chk("drain_busy_c", 32'(last_busy), 32'h1);
        out_ready = 2'b00;
        step(1'b0, none_v, 0);
        chk("drain_empty_valid", 32'(last_valid), 32'h0);
        chk("drain_empty_busy", 32'(last_busy), 32'h1);
        step(1'b0, none_v, 0);
        chk("idle_busy", 32'(last_busy), 32'h0);

        // Refill both flux registers, then reset mid-cycle.
        drive(1'b1, 2'b11, 2'b00, 2'b00, 9'h0D0);
        step(1'b0, none_v, 0);
        step(1'b0, none_v, 0);
        fifo_dout = 9'h1D1;
        step(1'b0, none_v, 0);
        chk("pre_rst_valid", 32'(out_valid), 32'h3);
        do_reset();

        // Random traffic; tags mostly match the grant, occasionally not.
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] er;
            logic       tg;
            if (c % 250 == 249) do_reset();
            en        = ($urandom_range(0, 9) != 0);
            mask      = 2'($urandom);
            empty     = 2'($urandom & $urandom);
            out_ready = 2'($urandom);
            er = model_read();
            tg = er[1];
            if ($urandom_range(0, 15) == 0) tg = ~tg;
            fifo_dout = {tg, 8'($urandom)};
            step(1'b0, none_v, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
